// File: rtl/unit_align_pipe_pkg.sv
// unit_align_pkg: shared definitions for the operand-alignment pipeline.
//   - Default exponent / stored-mantissa / guard widths (EW, MW, GW).
//   - calc_aw(): aligned-mantissa width AW = 1 + MW + GW (hidden bit included).
//   - operand_t: packed {sign, exp, mant} operand at the default widths.
package unit_align_pkg;

    localparam int unsigned EW_DEF = 8;
    localparam int unsigned MW_DEF = 23;
    localparam int unsigned GW_DEF = 4;

    function automatic int unsigned calc_aw(input int unsigned mw, input int unsigned gw);
        return 1 + mw + gw;
    endfunction

    localparam int unsigned AW_DEF = calc_aw(MW_DEF, GW_DEF);

    typedef struct packed {
        logic              sign;
        logic [EW_DEF-1:0] exp;
        logic [MW_DEF-1:0] mant;
    } operand_t;

endpackage

// File: rtl/unit_align_pipe_if.sv
// unit_align_pipe_if: handshake/data bundle for unit_align_pipe.
//   Input side : i_a, i_b (packed {sign, exp, mant}), i_valid, o_ready
//   Output side: o_valid, i_ready, o_augend, o_addend (AW bits), o_exp, o_swap
//   modport master: the block feeding operands and consuming results
//   modport slave : the alignment pipeline itself
interface unit_align_pipe_if
    import unit_align_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned MW = MW_DEF,
    parameter int unsigned GW = GW_DEF
);
    localparam int unsigned AW = calc_aw(MW, GW);

    logic [EW+MW:0] i_a;
    logic [EW+MW:0] i_b;
    logic           i_valid;
    logic           o_ready;
    logic           o_valid;
    logic           i_ready;
    logic [AW-1:0]  o_augend;
    logic [AW-1:0]  o_addend;
    logic [EW-1:0]  o_exp;
    logic           o_swap;

    modport master (
        output i_a, i_b, i_valid, i_ready,
        input  o_ready, o_valid, o_augend, o_addend, o_exp, o_swap
    );

    modport slave (
        input  i_a, i_b, i_valid, i_ready,
        output o_ready, o_valid, o_augend, o_addend, o_exp, o_swap
    );

endinterface

// File: rtl/unit_align_pipe_shrl_sticky.sv
// shrl_sticky: combinational logical right shift of a W-bit value.
//   din  : value to shift
//   sh   : shift amount (SW bits); any amount >= W yields zero
//   dout : shifted value
// Optional feature macro ALIGN_STICKY_EN: when defined, every bit shifted
// out (all of din when sh >= W) is ORed into dout[0]; when undefined the
// shifted-out bits are simply dropped.
module shrl_sticky #(
    parameter int unsigned W  = 28,
    parameter int unsigned SW = 8
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] sh,
    output logic [W-1:0]  dout
);

    logic          over;
    logic [W-1:0]  shifted;

    always_comb begin
        over    = 32'(sh) >= W;
        shifted = over ? '0 : (din >> sh);
    end

`ifdef ALIGN_STICKY_EN
    logic [W-1:0] lost_mask;
    logic         sticky;

    always_comb begin
        // Mask covers exactly the bits that fall off the bottom.
        lost_mask = over ? '1 : ~({W{1'b1}} << sh);
        sticky    = |(din & lost_mask);
        dout      = {shifted[W-1:1], shifted[0] | sticky};
    end
`else
    always_comb begin
        dout = shifted;
    end
`endif

endmodule

// File: rtl/unit_align_pipe.sv
// unit_align_pipe: two-stage operand alignment ahead of a floating-point adder.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_a/i_b operands with i_valid/o_ready, aligned results
//                  o_augend (larger magnitude), o_addend, o_exp, o_swap
//                  (o_swap = 1 when o_augend came from i_b) with o_valid/i_ready.
// Stage 1 picks the larger-exponent operand and the exponent difference;
// stage 2 shifts the smaller one and orders the pair by magnitude.
// Optional feature macro ALIGN_STICKY_EN (in shrl_sticky): sticky OR of
// shifted-out bits into bit 0 of the shifted addend.
module unit_align_pipe
    import unit_align_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned MW = MW_DEF,
    parameter int unsigned GW = GW_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    unit_align_pipe_if.slave  bus
);

    localparam int unsigned AW = calc_aw(MW, GW);

    logic          en;
    logic [EW-1:0] exp_a, exp_b, eff_a, eff_b;
    logic          hid_a, hid_b;
    logic [AW-1:0] ext_a, ext_b;
    logic          b_bigger_exp;
    logic          sign_unused;

    // Stage 1 registers
    logic          s1_valid;
    logic [EW-1:0] s1_d;
    logic [AW-1:0] s1_em;
    logic [AW-1:0] s1_el;
    logic [EW-1:0] s1_exp;
    logic          s1_em_is_b;

    // Stage 2 (output) registers
    logic          s2_valid;
    logic [AW-1:0] s2_augend;
    logic [AW-1:0] s2_addend;
    logic [EW-1:0] s2_exp;
    logic          s2_swap;

    logic [AW-1:0] el_shifted;

    always_comb begin
        en           = !s2_valid || bus.i_ready;
        exp_a        = bus.i_a[EW+MW-1:MW];
        exp_b        = bus.i_b[EW+MW-1:MW];
        hid_a        = |exp_a;
        hid_b        = |exp_b;
        eff_a        = hid_a ? exp_a : EW'(1);
        eff_b        = hid_b ? exp_b : EW'(1);
        ext_a        = {hid_a, bus.i_a[MW-1:0], {GW{1'b0}}};
        ext_b        = {hid_b, bus.i_b[MW-1:0], {GW{1'b0}}};
        b_bigger_exp = eff_b > eff_a;
        // Signs play no part in magnitude alignment.
        sign_unused  = bus.i_a[EW+MW] ^ bus.i_b[EW+MW];
    end

    assign bus.o_ready  = en;
    assign bus.o_valid  = s2_valid;
    assign bus.o_augend = s2_augend;
    assign bus.o_addend = s2_addend;
    assign bus.o_exp    = s2_exp;
    assign bus.o_swap   = s2_swap;

    shrl_sticky #(
        .W  (AW),
        .SW (EW)
    ) u_shrl_sticky (
        .din  (s1_el),
        .sh   (s1_d),
        .dout (el_shifted)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_d       <= '0;
            s1_em      <= '0;
            s1_el      <= '0;
            s1_exp     <= '0;
            s1_em_is_b <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_em_is_b <= b_bigger_exp;
                if (b_bigger_exp) begin
                    s1_d   <= eff_b - eff_a;
                    s1_em  <= ext_b;
                    s1_el  <= ext_a;
                    s1_exp <= eff_b;
                end else begin
                    s1_d   <= eff_a - eff_b;
                    s1_em  <= ext_a;
                    s1_el  <= ext_b;
                    s1_exp <= eff_a;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid  <= 1'b0;
            s2_augend <= '0;
            s2_addend <= '0;
            s2_exp    <= '0;
            s2_swap   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_exp <= s1_exp;
                // Ties keep the larger-exponent operand (A on equal
                // exponents), so equal magnitudes report o_swap = 0.
                if (s1_em >= el_shifted) begin
                    s2_augend <= s1_em;
                    s2_addend <= el_shifted;
                    s2_swap   <= s1_em_is_b;
                end else begin
                    s2_augend <= el_shifted;
                    s2_addend <= s1_em;
                    s2_swap   <= !s1_em_is_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_unit_align_pipe.sv
// tb_unit_align_pipe: directed, table-driven bench for unit_align_pipe at
// default widths, plus hand-written stall and mid-flight reset sequences.
// Expected values for sticky-dependent vectors follow ALIGN_STICKY_EN.
module tb_unit_align_pipe;
    import unit_align_pkg::*;

`ifdef ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [27:0] aug;
        logic [27:0] add;
        logic [7:0]  ex;
        logic        sw;
    } vec_t;

    localparam int unsigned NV = 11;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [NV];

    unit_align_pipe_if #(.EW(8), .MW(23), .GW(4)) bus ();

    unit_align_pipe #(.EW(8), .MW(23), .GW(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input vec_t v);
        chk({name, ".o_valid"},  64'(bus.o_valid),  64'(1'b1));
        chk({name, ".o_augend"}, 64'(bus.o_augend), 64'(v.aug));
        chk({name, ".o_addend"}, 64'(bus.o_addend), 64'(v.add));
        chk({name, ".o_exp"},    64'(bus.o_exp),    64'(v.ex));
        chk({name, ".o_swap"},   64'(bus.o_swap),   64'(v.sw));
    endtask

    task automatic drive(input vec_t v);
        bus.i_a     = v.a;
        bus.i_b     = v.b;
        bus.i_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //          a             b             augend        addend               exp    swap
        vecs[0]  = '{32'h3F800000, 32'h3F000000, 28'h8000000, 28'h4000000,          8'd127, 1'b0};
        vecs[1]  = '{32'h3F000000, 32'h3F800000, 28'h8000000, 28'h4000000,          8'd127, 1'b1};
        vecs[2]  = '{32'h3F800000, 32'h3FC00000, 28'hC000000, 28'h8000000,          8'd127, 1'b1};
        vecs[3]  = '{32'h4B800000, 32'h3F800001, 28'h8000000, STK ? 28'h9 : 28'h8,  8'h97,  1'b0};
        vecs[4]  = '{32'h4F800000, 32'h3F800000, 28'h8000000, STK ? 28'h1 : 28'h0,  8'h9F,  1'b0};
        vecs[5]  = '{32'h00000001, 32'h00000001, 28'h0000010, 28'h0000010,          8'd1,   1'b0};
        vecs[6]  = '{32'h40490FDB, 32'h40490FDB, 28'hC90FDB0, 28'hC90FDB0,          8'h80,  1'b0};
        vecs[7]  = '{32'h3F800000, 32'hC0000000, 28'h8000000, 28'h4000000,          8'h80,  1'b1};
        vecs[8]  = '{32'h00400000, 32'h00800000, 28'h8000000, 28'h4000000,          8'd1,   1'b1};
        vecs[9]  = '{32'h4D000000, 32'h3FFFFFFF, 28'h8000000, 28'h1,                8'h9A,  1'b0};
        vecs[10] = '{32'h4D800000, 32'h3F800000, 28'h8000000, STK ? 28'h1 : 28'h0,  8'h9B,  1'b0};

        rst         = 1'b1;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        chk("reset.o_valid",  64'(bus.o_valid),  64'(1'b0));
        chk("reset.o_ready",  64'(bus.o_ready),  64'(1'b1));
        chk("reset.o_augend", 64'(bus.o_augend), 64'(0));
        chk("reset.o_addend", 64'(bus.o_addend), 64'(0));
        chk("reset.o_exp",    64'(bus.o_exp),    64'(0));
        chk("reset.o_swap",   64'(bus.o_swap),   64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle.o_valid", 64'(bus.o_valid), 64'(1'b0));

        // One transaction at a time: not valid after one edge, valid after two.
        for (int unsigned i = 0; i < NV; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("vec%0d.lat1", i), 64'(bus.o_valid), 64'(1'b0));
            bus.i_valid = 1'b0;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i]);
        end
        tick();
        chk("drain.o_valid", 64'(bus.o_valid), 64'(1'b0));

        // Stall: three back-to-back inputs with the consumer not ready.
        bus.i_ready = 1'b0;
        drive(vecs[0]);
        tick();
        chk("stall.fill1", 64'(bus.o_valid), 64'(1'b0));
        drive(vecs[1]);
        tick();
        chk("stall.o_ready_low", 64'(bus.o_ready), 64'(1'b0));
        drive(vecs[2]);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("stall.hold%0d", k), vecs[0]);
            chk($sformatf("stall.o_ready%0d", k), 64'(bus.o_ready), 64'(1'b0));
        end
        bus.i_ready = 1'b1;
        #1;
        chk("stall.o_ready_up", 64'(bus.o_ready), 64'(1'b1));
        chk_out("stall.out0", vecs[0]);
        tick();
        bus.i_valid = 1'b0;
        chk_out("stall.out1", vecs[1]);
        tick();
        chk_out("stall.out2", vecs[2]);
        tick();
        chk("stall.empty", 64'(bus.o_valid), 64'(1'b0));

        // Reset with two transactions in flight.
        drive(vecs[3]);
        tick();
        drive(vecs[4]);
        tick();
        bus.i_valid = 1'b0;
        chk_out("rstseq.before", vecs[3]);
        #2;
        rst = 1'b1;
        #1;
        chk("rstseq.o_valid",  64'(bus.o_valid),  64'(1'b0));
        chk("rstseq.o_augend", 64'(bus.o_augend), 64'(0));
        chk("rstseq.o_addend", 64'(bus.o_addend), 64'(0));
        chk("rstseq.o_exp",    64'(bus.o_exp),    64'(0));
        chk("rstseq.o_swap",   64'(bus.o_swap),   64'(1'b0));
        chk("rstseq.o_ready",  64'(bus.o_ready),  64'(1'b1));
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rstseq.no_stale", 64'(bus.o_valid), 64'(1'b0));
        drive(vecs[5]);
        tick();
        chk("rstseq.lat1", 64'(bus.o_valid), 64'(1'b0));
        bus.i_valid = 1'b0;
        tick();
        chk_out("rstseq.after", vecs[5]);
        tick();
        chk("rstseq.empty", 64'(bus.o_valid), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unit_align_pipe.md
UNIT_ALIGN_PIPE -- requirements
Module: unit_align_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width.
REQ-002 SHALL have parameter MW, default 23, stored mantissa width.
REQ-003 SHALL have parameter GW, default 4, appended low bits (guard/round/sticky); AW = 1+MW+GW (default 28).
REQ-004 SHALL have port i_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports i_a, i_b  in  1+EW+MW each  operands, packed {sign, exp, mant}.
REQ-007 SHALL have ports i_valid  in  1 and o_ready  out  1  input handshake.
REQ-008 SHALL have ports o_valid  out  1 and i_ready  in  1  output handshake.
REQ-009 SHALL have ports o_augend, o_addend  out  AW each  aligned mantissas, larger magnitude first.
REQ-010 SHALL have port o_exp  out  EW  larger effective exponent.
REQ-011 SHALL have port o_swap  out  1  1 when o_augend came from i_b.

Function
REQ-012 SHALL form each extended mantissa as {hidden, mant, GW zeros}; hidden = (exp != 0); effective exp = max(exp, 1).
REQ-013 Stage 1 SHALL register exponent difference d = |effA-effB|, larger-exp operand M_em (A on equal exponents), smaller M_el, and o_exp.
REQ-014 Stage 2 SHALL right-shift M_el by d, compare M_em >= shifted value, and register augend = larger, addend = smaller, o_swap.
REQ-015 Shift amount d >= AW SHALL yield shifted value of 0 before sticky merge.
REQ-016 Full equality of magnitudes SHALL give o_augend from i_a, o_swap = 0.
REQ-017 Latency SHALL be exactly 2 cycles from accepted input (i_valid && o_ready) to o_valid, absent stalls.
REQ-018 Pipeline enable SHALL be en = !o_valid || i_ready; o_ready = en; both stages advance only when en = 1.
REQ-019 While o_valid && !i_ready, all outputs SHALL hold stable.
REQ-020 Bubbles SHALL propagate as valid = 0 per stage; transaction order SHALL be preserved; none dropped or duplicated.
REQ-021 Stage data registers SHALL load only when en && stage-input valid.

Reset
REQ-022 On i_rst = 1, both stage valids, o_valid, o_augend, o_addend, o_exp, o_swap SHALL be 0 immediately, without clock.
REQ-023 o_ready SHALL be 1 while in reset and after it (pipeline empty).
REQ-024 Reset mid-operation SHALL discard all in-flight transactions.

Configuration
REQ-025 Macro ALIGN_STICKY_EN defined: bit 0 of shifted addend SHALL be OR of bit 0 and all bits shifted out (including d >= AW case).
REQ-026 Macro ALIGN_STICKY_EN undefined: shifted-out bits SHALL be discarded (pure truncation); no sticky logic present.

Structure
REQ-027 Package unit_align_pkg SHALL hold default EW/MW/GW, the AW computation, and the packed operand typedef.
REQ-028 Shifting SHALL live in sub-module shrl_sticky (parametrised width, sticky path under ALIGN_STICKY_EN).

Verification
REQ-029 A=0x3F800000, B=0x3F000000, i_ready=1 -> after 2 cycles augend 0x8000000, addend 0x4000000, o_exp 127, o_swap 0.
REQ-030 A=0x3F000000, B=0x3F800000 -> augend 0x8000000, addend 0x4000000, o_swap 1; A=0x3F800000, B=0x3FC00000 -> augend 0xC000000, addend 0x8000000, o_swap 1.
REQ-031 A=0x4B800000, B=0x3F800001 (d=24) -> addend 0x9 with ALIGN_STICKY_EN, 0x8 without; A=0x4F800000, B=0x3F800000 (d=32) -> addend 0x1 / 0x0.
REQ-032 Three back-to-back inputs with i_ready=0 -> o_ready falls after pipeline fills, outputs stable; raising i_ready -> all three delivered in order, one per cycle.
REQ-033 Assert i_rst with 2 transactions in flight -> o_valid 0 and outputs 0 asynchronously; post-reset transaction emerges with 2-cycle latency and no stale data.
REQ-034 A=B=0x00000001 (denormal) -> augend 0x10, addend 0x10, o_exp 1, o_swap 0.
